// File: rtl/fpa_normalizer.sv
// Post-add normalise/round stage for binary32 addition: iterative left-shift
// normaliser, round-to-nearest-even, valid/ready handshakes on both sides.
// Optional status flags output enabled by defining FPA_NORM_FLAGS_EN.
module fpa_normalizer #(
    parameter int LSTEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [27:0] mantis,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
`ifdef FPA_NORM_FLAGS_EN
    ,
    output logic [2:0]  flags
`endif
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    // Bits that must all be clear before a multi-bit shift is safe.
    localparam logic [27:0] TOP_MASK = 28'(((1 << LSTEP) - 1) << (27 - LSTEP));

    state_t      state, state_n;
    logic        s_q, s_n;
    logic [9:0]  e_q, e_n;
    logic [27:0] m_q, m_n;
    logic [31:0] result_n;

    logic        round_up;
    logic [23:0] round_sum;
    logic [9:0]  round_e;
    logic [22:0] round_frac;

`ifdef FPA_NORM_FLAGS_EN
    logic [2:0]  flags_n;
`endif

    // m[26] is always set in ROUND, so a carry out of the fraction field
    // is the same as a carry out of the hidden bit.
    assign round_up   = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    assign round_sum  = {1'b0, m_q[25:3]} + {23'b0, round_up};
    assign round_e    = e_q + {9'b0, round_sum[23]};
    assign round_frac = round_sum[23] ? 23'b0 : round_sum[22:0];

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    always_comb begin
        state_n  = state;
        s_n      = s_q;
        e_n      = e_q;
        m_n      = m_q;
        result_n = result;
`ifdef FPA_NORM_FLAGS_EN
        flags_n  = flags;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    s_n     = sign;
                    e_n     = {2'b00, exp};
                    m_n     = mantis;
`ifdef FPA_NORM_FLAGS_EN
                    flags_n = 3'b000;
`endif
                    state_n = NORM;
                end
            end
            NORM: begin
                if (m_q == 28'd0) begin
                    result_n = {s_q, 31'b0};
                    state_n  = DONE;
                end else if (m_q[27]) begin
                    m_n     = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
                    e_n     = e_q + 10'd1;
                    state_n = ROUND;
                end else if (m_q[26]) begin
                    state_n = ROUND;
                end else if (e_q <= 10'd1) begin
                    result_n = {s_q, 31'b0};
`ifdef FPA_NORM_FLAGS_EN
                    flags_n  = 3'b011;
`endif
                    state_n  = DONE;
                end else if (((m_q & TOP_MASK) == 28'd0) && (e_q > 10'(LSTEP))) begin
                    m_n = m_q << LSTEP;
                    e_n = e_q - 10'(LSTEP);
                end else begin
                    m_n = m_q << 1;
                    e_n = e_q - 10'd1;
                end
            end
            ROUND: begin
                if (round_e >= 10'd255) begin
                    result_n = {s_q, 8'hFF, 23'b0};
`ifdef FPA_NORM_FLAGS_EN
                    flags_n  = {1'b1, 1'b0, |m_q[2:0]};
`endif
                end else begin
                    result_n = {s_q, round_e[7:0], round_frac};
`ifdef FPA_NORM_FLAGS_EN
                    flags_n  = {2'b00, |m_q[2:0]};
`endif
                end
                state_n = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            s_q    <= 1'b0;
            e_q    <= 10'd0;
            m_q    <= 28'd0;
            result <= 32'd0;
`ifdef FPA_NORM_FLAGS_EN
            flags  <= 3'b000;
`endif
        end else begin
            state  <= state_n;
            s_q    <= s_n;
            e_q    <= e_n;
            m_q    <= m_n;
            result <= result_n;
`ifdef FPA_NORM_FLAGS_EN
            flags  <= flags_n;
`endif
        end
    end

endmodule

// File: tb/tb_fpa_normalizer.sv
// Bench for fpa_normalizer (default LSTEP=1): directed vector table, handshake
// and reset sequences, random vectors against a value-level model. Flag checks
// are compiled in when FPA_NORM_FLAGS_EN is defined.
module tb_fpa_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mantis;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
`ifdef FPA_NORM_FLAGS_EN
    logic [2:0]  flags;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        logic [31:0] res;
        int          lat;
        logic [2:0]  fl;
    } vec_t;

    fpa_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .exp       (exp),
        .mantis    (mantis),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef FPA_NORM_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Value-level model: locate the leading one, normalise in one step,
    // then round the integer significand to nearest-even.
    function automatic void model(input logic s, input logic [7:0] e8, input logic [27:0] m,
                                  output logic [31:0] res, output int lat, output logic [2:0] fl);
        int     e;
        int     p;
        int     k;
        int     rem;
        longint n;
        longint q;
        e  = int'(e8);
        fl = 3'b000;
        if (m == 28'd0) begin
            res = {s, 31'b0};
            lat = 1;
            return;
        end
        p = 27;
        while (!m[p]) p--;
        n = longint'(m);
        if (p == 27) begin
            n   = (n >> 1) | (n & 1);
            e   = e + 1;
            lat = 2;
        end else if (p == 26) begin
            lat = 2;
        end else begin
            k = 26 - p;
            if (e >= k + 1) begin
                n   = n << k;
                e   = e - k;
                lat = 2 + k;
            end else begin
                res = {s, 31'b0};
                fl  = 3'b011;
                lat = (e <= 1) ? 1 : e;
                return;
            end
        end
        q   = n >> 3;
        rem = int'(n & 7);
        if (rem > 4 || (rem == 4 && q[0])) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            e = e + 1;
        end
        if (rem != 0) fl[0] = 1'b1;
        if (e >= 255) begin
            res   = {s, 8'hFF, 23'b0};
            fl[2] = 1'b1;
        end else begin
            res = {s, 8'(e), 23'(q)};
        end
    endfunction

    task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [27:0] m, output int lat);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("in_ready_wait", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        sign     = s;
        exp      = e;
        mantis   = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mantis   = 28'($urandom);
        exp      = 8'($urandom);
        lat      = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic releaseOutput();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("out_valid_drop", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic runVector(input string name, input vec_t v);
        int lat;
        applyStimulus(v.s, v.e, v.m, lat);
        checkOutput({name, "_result"}, result, v.res);
        checkOutput({name, "_latency"}, 32'(lat), 32'(v.lat));
`ifdef FPA_NORM_FLAGS_EN
        checkOutput({name, "_flags"}, {29'b0, flags}, {29'b0, v.fl});
`endif
        releaseOutput();
    endtask

    initial begin
        vec_t vecs[9];
        vec_t v;
        int   lat;
        int   waited;

        vecs[0] = '{1'b0, 8'h7F, 28'h8000000, 32'h40000000, 2,  3'b000};
        vecs[1] = '{1'b0, 8'h7F, 28'h0000008, 32'h34000000, 25, 3'b000};
        vecs[2] = '{1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 2,  3'b001};
        vecs[3] = '{1'b0, 8'h7F, 28'h400000C, 32'h3F800002, 2,  3'b001};
        vecs[4] = '{1'b0, 8'h7F, 28'h7FFFFFC, 32'h40000000, 2,  3'b001};
        vecs[5] = '{1'b0, 8'hFE, 28'h8000000, 32'h7F800000, 2,  3'b100};
        vecs[6] = '{1'b0, 8'h02, 28'h1000000, 32'h00000000, 2,  3'b011};
        vecs[7] = '{1'b1, 8'h55, 28'h0000000, 32'h80000000, 1,  3'b000};
        vecs[8] = '{1'b1, 8'h80, 28'h4000000, 32'hC0000000, 2,  3'b000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        sign      = 1'b0;
        exp       = 8'h00;
        mantis    = 28'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready_low", {31'b0, in_ready}, 32'd0);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready_high", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Result must hold while downstream stalls, with no new input accepted.
        applyStimulus(1'b1, 8'h55, 28'h0, lat);
        checkOutput("stall_latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stall_result", result, 32'h80000000);
            checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        releaseOutput();

        // Leave a nonzero result, then reset in the middle of a long NORM run.
        runVector("pre_reset", vecs[0]);
        @(negedge clk);
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b1;
        sign     = 1'b0;
        exp      = 8'h7F;
        mantis   = 28'h0000008;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        runVector("post_reset", vecs[0]);

        for (int i = 0; i < 300; i++) begin
            v.s = 1'($urandom);
            v.e = (i % 4 == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
            v.m = 28'($urandom) >> $urandom_range(0, 27);
            model(v.s, v.e, v.m, v.res, v.lat, v.fl);
            runVector("rand", v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
